// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell reused LSB first over WIDTH cycles.
// Three-state control (IDLE -> RUN -> DONE -> IDLE); D/bn hold the last completed result.
module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             bn
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  // Holds the low WIDTH-1 result bits; the final (MSB) bit goes straight into D.
  logic [WIDTH-2:0] res_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;

  logic bit_a, bit_b, diff_bit, br_next, last_bit;

  // Full-subtractor cell applied to the current operand LSBs.
  always_comb begin
    bit_a    = a_q[0];
    bit_b    = b_q[0];
    diff_bit = bit_a ^ bit_b ^ br_q;
    br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (start) state_d = StRun;
      end
      StRun: begin
        busy = 1'b1;
        if (last_bit) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Operand shifters, borrow, bit counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      br_q  <= 1'b0;
      cnt_q <= '0;
      D     <= '0;
      bn    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            br_q  <= b;
            cnt_q <= '0;
          end
        end
        StRun: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_next;
          cnt_q <= cnt_q + CW'(1);
          res_q <= (WIDTH-1)'({diff_bit, res_q} >> 1);
          if (last_bit) begin
            D  <= {diff_bit, res_q};
            bn <= br_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench: directed vector table, continuous-start, reset corners and
// randomized checks of WIDTH=8 and WIDTH=16 instances against an arithmetic model.
module tb_serial_subtractor_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start8, bin8, ready8, busy8, done8, bn8;
  logic [7:0]  a8, bs8, d8;
  logic        start16, bin16, ready16, busy16, done16, bn16;
  logic [15:0] a16, bs16, d16;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(bs8), .b(bin8),
    .ready(ready8), .busy(busy8), .done(done8), .D(d8), .bn(bn8)
  );

  serial_subtractor_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .A(a16), .B(bs16), .b(bin16),
    .ready(ready16), .busy(busy16), .done(done16), .D(d16), .bn(bn16)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: D = (A - B - b) mod 2^w, bn = (A < B + b).
  function automatic logic [16:0] model(input int w, input logic [15:0] a,
                                        input logic [15:0] bb, input logic bi);
    longint diff;
    longint mask;
    logic [16:0] r;
    diff = longint'(a) - longint'(bb) - longint'(bi);
    mask = (longint'(1) << w) - 1;
    r[15:0] = 16'(diff & mask);
    r[16]   = (diff < 0);
    return r;
  endfunction

  task automatic wait_ready(input bit w16);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((w16 ? ready16 : ready8) == 1'b1) break;
    end
    chk("ready_before_start", w16 ? ready16 : ready8, 1);
  endtask

  // One operation; inputs are scrambled right after acceptance.
  task automatic op(input bit w16, input logic [15:0] a, input logic [15:0] bb, input logic bi,
                    output logic [15:0] d, output logic bo, output int bsy);
    int lat;
    lat = -1;
    bsy = 0;
    wait_ready(w16);
    if (w16) begin
      start16 = 1'b1; a16 = a; bs16 = bb; bin16 = bi;
    end else begin
      start8 = 1'b1; a8 = a[7:0]; bs8 = bb[7:0]; bin8 = bi;
    end
    @(posedge clk);
    #1;
    start8 = 1'b0; start16 = 1'b0;
    a8 = 8'($urandom); bs8 = 8'($urandom); bin8 = 1'($urandom);
    a16 = 16'($urandom); bs16 = 16'($urandom); bin16 = 1'($urandom);
    if (w16 ? busy16 : busy8) bsy++;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (w16 ? busy16 : busy8) bsy++;
      if (w16 ? done16 : done8) begin
        lat = k;
        break;
      end
    end
    chk(w16 ? "latency16" : "latency8", lat, w16 ? 16 : 8);
    d  = w16 ? d16 : {8'h00, d8};
    bo = w16 ? bn16 : bn8;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] d;
    logic       bn;
  } vec_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
  } opnd_t;

  initial begin
    vec_t  vecs[6];
    opnd_t q[$];
    opnd_t e;
    logic [15:0] got_d;
    logic        got_bn;
    logic [16:0] m;
    logic [7:0]  prev_d;
    int bsy, last_done, ndone, cnt;

    vecs[0] = '{a: 8'h00, b: 8'h01, bi: 1'b0, d: 8'hFF, bn: 1'b1};
    vecs[1] = '{a: 8'h80, b: 8'h7F, bi: 1'b1, d: 8'h00, bn: 1'b0};
    vecs[2] = '{a: 8'h00, b: 8'hFF, bi: 1'b1, d: 8'h00, bn: 1'b1};
    vecs[3] = '{a: 8'hFF, b: 8'h00, bi: 1'b0, d: 8'hFF, bn: 1'b0};
    vecs[4] = '{a: 8'h10, b: 8'h10, bi: 1'b1, d: 8'hFF, bn: 1'b1};
    vecs[5] = '{a: 8'h35, b: 8'h12, bi: 1'b0, d: 8'h23, bn: 1'b0};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; bs8 = '0; bin8 = 1'b0;
    start16 = 1'b0; a16 = '0; bs16 = '0; bin16 = 1'b0;
    #12;
    chk("reset_ready", ready8, 1);
    chk("reset_busy", busy8, 0);
    chk("reset_done", done8, 0);
    chk("reset_d", d8, 0);
    chk("reset_bn", bn8, 0);
    chk("reset_ready16", ready16, 1);
    chk("reset_d16", d16, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors; 0x35-0x12 also checks busy span of WIDTH cycles.
    for (int i = 0; i < 6; i++) begin
      op(1'b0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].bi, got_d, got_bn, bsy);
      chk($sformatf("vec%0d_d", i), got_d, vecs[i].d);
      chk($sformatf("vec%0d_bn", i), got_bn, vecs[i].bn);
      chk($sformatf("vec%0d_busy_cycles", i), bsy, 8);
    end

    // Result must hold through the following IDLE cycles.
    repeat (3) @(negedge clk);
    chk("d_hold_idle", d8, 8'h23);

    // Start held high, operands changing every cycle.
    wait_ready(1'b0);
    start8 = 1'b1;
    a8 = 8'($urandom); bs8 = 8'($urandom); bin8 = 1'($urandom);
    last_done = -1;
    ndone = 0;
    prev_d = d8;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (ready8) q.push_back('{a: a8, b: bs8, bi: bin8});
      if (done8) begin
        ndone++;
        if (q.size() > 0) begin
          e = q.pop_front();
          m = model(8, {8'h00, e.a}, {8'h00, e.b}, e.bi);
          chk("cont_d", d8, m[7:0]);
          chk("cont_bn", bn8, m[16]);
        end else begin
          chk("cont_spurious_done", done8, 0);
        end
        if (last_done >= 0) chk("cont_period", cyc - last_done, 10);
        last_done = cyc;
      end else begin
        chk("cont_d_stable", d8, prev_d);
      end
      prev_d = d8;
      @(posedge clk);
      #1;
      a8 = 8'($urandom); bs8 = 8'($urandom); bin8 = 1'($urandom);
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("cont_done_count", ndone, 6);

    // Give D a known nonzero value, then abort mid-RUN with an async reset.
    op(1'b0, 16'h0035, 16'h0012, 1'b0, got_d, got_bn, bsy);
    chk("pre_rst_d", got_d, 16'h0023);
    wait_ready(1'b0);
    start8 = 1'b1; a8 = 8'h5A; bs8 = 8'h21; bin8 = 1'b0;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_d", d8, 0);
    chk("async_rst_bn", bn8, 0);
    chk("async_rst_busy", busy8, 0);
    chk("async_rst_done", done8, 0);
    chk("async_rst_ready", ready8, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) cnt++;
    end
    chk("rst_no_done", cnt, 0);
    chk("rst_ready_after", ready8, 1);
    op(1'b0, 16'h005A, 16'h0021, 1'b0, got_d, got_bn, bsy);
    chk("post_rst_d", got_d, 16'h0039);
    chk("post_rst_bn", got_bn, 0);

    // Start while reset is high at the edge is ignored; accepted on the next edge.
    @(negedge clk);
    rst = 1'b1;
    start8 = 1'b1; a8 = 8'h01; bs8 = 8'h02; bin8 = 1'b0;
    @(posedge clk);
    #1;
    chk("start_in_rst_ignored", busy8, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    chk("start_after_rst_busy", busy8, 1);
    cnt = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (done8) begin
        cnt = k;
        break;
      end
    end
    chk("rst_edge_latency", cnt, 8);
    chk("rst_edge_d", d8, 8'hFF);
    chk("rst_edge_bn", bn8, 1);

    // Randomized checks, both widths.
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rbi;
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      rbi = 1'($urandom);
      op(1'b0, ra, rb, rbi, got_d, got_bn, bsy);
      m = model(8, ra, rb, rbi);
      chk("rand8", {got_bn, got_d}, {m[16], 8'h00, m[7:0]});
    end
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rbi;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rbi = 1'($urandom);
      op(1'b1, ra, rb, rbi, got_d, got_bn, bsy);
      m = model(16, ra, rb, rbi);
      chk("rand16", {got_bn, got_d}, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
